// File: rtl/led_pkg.sv
// Shared constants for the LED flicker mode controller: mode encoding,
// mode width and board-default timing values for a 25 MHz clock.
package led_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_OFF      = 3'd0;
   localparam logic [MODE_W-1:0] MODE_ALL_10HZ = 3'd1;
   localparam logic [MODE_W-1:0] MODE_ALL_5HZ  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_ALL_2HZ  = 3'd3;
   localparam logic [MODE_W-1:0] MODE_ALL_1HZ  = 3'd4;
   localparam logic [MODE_W-1:0] MODE_SPLIT    = 3'd5;
   localparam logic [MODE_W-1:0] MODE_CHASE    = 3'd6;
   localparam logic [MODE_W-1:0] MODE_ALL_ON   = 3'd7;

   localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
   localparam int DEFAULT_CHASE_COUNT    = 12500000;

   // LED vector is ordered {LED1, LED2, LED3, LED4}; position 0 lights LED1.
   function automatic logic [3:0] chaseOneHot(input logic [1:0] pos);
      logic [3:0] pattern;
      pattern = 4'b1000 >> pos;
      return pattern;
   endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability counter; the output level
// only follows the button once it has held a new value for g_DEBOUNCE_LIMIT cycles.
module debounce_filter
   import led_pkg::*;
#(
   parameter int g_DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
)(
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Raw,
   output logic o_Level
);

   localparam int CNT_W = (g_DEBOUNCE_LIMIT > 1) ? $clog2(g_DEBOUNCE_LIMIT) : 1;
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(g_DEBOUNCE_LIMIT - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Any cycle where the synced input agrees with the accepted level restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == LIMIT_M1) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= i_Raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_Level = level_q;

endmodule

// File: rtl/led_flicker_mode_ctrl.sv
// Button-driven mode sequencer that selects which blinker rate, chase pattern
// or constant drives the four board LEDs.
module led_flicker_mode_ctrl
   import led_pkg::*;
#(
   parameter int g_DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
   parameter int g_CHASE_COUNT    = DEFAULT_CHASE_COUNT
)(
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic              i_Switch_1,
   input  logic              i_Blink_10Hz,
   input  logic              i_Blink_5Hz,
   input  logic              i_Blink_2Hz,
   input  logic              i_Blink_1Hz,
   output logic              o_LED_1,
   output logic              o_LED_2,
   output logic              o_LED_3,
   output logic              o_LED_4,
   output logic [MODE_W-1:0] o_Mode
);

   localparam int CHASE_W = (g_CHASE_COUNT > 1) ? $clog2(g_CHASE_COUNT) : 1;
   localparam logic [CHASE_W-1:0] CHASE_M1 = CHASE_W'(g_CHASE_COUNT - 1);

   logic               btnLevel;
   logic               btnLevelPrev_q;
   logic               pressEdge;
   logic [MODE_W-1:0]  mode_q;
   logic [MODE_W-1:0]  mode_d;
   logic [CHASE_W-1:0] chaseCnt_q;
   logic [CHASE_W-1:0] chaseCnt_d;
   logic [1:0]         chasePos_q;
   logic [1:0]         chasePos_d;
   logic [3:0]         led_q;
   logic [3:0]         led_d;

   debounce_filter #(
      .g_DEBOUNCE_LIMIT(g_DEBOUNCE_LIMIT)
   ) u_debounce (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Raw   (i_Switch_1),
      .o_Level (btnLevel)
   );

   assign pressEdge = btnLevel & ~btnLevelPrev_q;

   // The 3-bit mode naturally wraps from ALL_ON back to OFF.
   always_comb begin
      mode_d = mode_q;
      if (pressEdge) begin
         mode_d = mode_q + 1'b1;
      end
   end

   // A mode change takes priority over a due chase step so CHASE is always entered clean.
   always_comb begin
      chaseCnt_d = '0;
      chasePos_d = '0;
      if (!pressEdge && (mode_q == MODE_CHASE)) begin
         chasePos_d = chasePos_q;
         if (chaseCnt_q == CHASE_M1) begin
            chasePos_d = chasePos_q + 1'b1;
         end else begin
            chaseCnt_d = chaseCnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      led_d = '0;
      case (mode_q)
         MODE_OFF:      led_d = '0;
         MODE_ALL_10HZ: led_d = {4{i_Blink_10Hz}};
         MODE_ALL_5HZ:  led_d = {4{i_Blink_5Hz}};
         MODE_ALL_2HZ:  led_d = {4{i_Blink_2Hz}};
         MODE_ALL_1HZ:  led_d = {4{i_Blink_1Hz}};
         MODE_SPLIT:    led_d = {i_Blink_10Hz, i_Blink_5Hz, i_Blink_2Hz, i_Blink_1Hz};
         MODE_CHASE:    led_d = chaseOneHot(chasePos_q);
         MODE_ALL_ON:   led_d = '1;
         default:       led_d = '0;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         btnLevelPrev_q <= 1'b0;
         mode_q         <= MODE_OFF;
         chaseCnt_q     <= '0;
         chasePos_q     <= '0;
         led_q          <= '0;
      end else begin
         btnLevelPrev_q <= btnLevel;
         mode_q         <= mode_d;
         chaseCnt_q     <= chaseCnt_d;
         chasePos_q     <= chasePos_d;
         led_q          <= led_d;
      end
   end

   assign o_LED_1 = led_q[3];
   assign o_LED_2 = led_q[2];
   assign o_LED_3 = led_q[1];
   assign o_LED_4 = led_q[0];
   assign o_Mode  = mode_q;

endmodule

// File: tb/tb_led_flicker_mode_ctrl.sv
// Directed bench for led_flicker_mode_ctrl with a short debounce (4) and chase step (3)
// so every mode, the chase sequence and the press/chase-step collision fit in a few hundred cycles.
module tb_led_flicker_mode_ctrl;

   logic       clk;
   logic       rstN;
   logic       sw;
   logic [3:0] blink;
   logic       led1;
   logic       led2;
   logic       led3;
   logic       led4;
   logic [2:0] mode;
   logic [3:0] leds;

   int checkCount;
   int errorCount;

   led_flicker_mode_ctrl #(
      .g_DEBOUNCE_LIMIT(4),
      .g_CHASE_COUNT   (3)
   ) dut (
      .i_Clk        (clk),
      .i_Rst_L      (rstN),
      .i_Switch_1   (sw),
      .i_Blink_10Hz (blink[3]),
      .i_Blink_5Hz  (blink[2]),
      .i_Blink_2Hz  (blink[1]),
      .i_Blink_1Hz  (blink[0]),
      .o_LED_1      (led1),
      .o_LED_2      (led2),
      .o_LED_3      (led3),
      .o_LED_4      (led4),
      .o_Mode       (mode)
   );

   assign leds = {led1, led2, led3, led4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive inputs, then land 1 time unit after the next rising edge.
   task automatic applyStimulus(input logic s, input logic [3:0] b);
      sw    = s;
      blink = b;
      @(posedge clk);
      #1;
   endtask

   task automatic pressButton(input int holdCycles);
      for (int i = 0; i < holdCycles; i++) applyStimulus(1'b1, blink);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, blink);
   endtask

   function automatic logic [3:0] expectedLeds(input int m, input logic [3:0] b);
      logic [3:0] e;
      case (m)
         1:       e = {4{b[3]}};
         2:       e = {4{b[2]}};
         3:       e = {4{b[1]}};
         4:       e = {4{b[0]}};
         5:       e = b;
         default: e = 4'b0000;
      endcase
      return e;
   endfunction

   // Blink inputs follow counter bits so each rate has a distinct toggle period.
   task automatic checkMapping(input int m);
      logic [3:0] b;
      for (int i = 4; i < 12; i++) begin
         b = {i[0], i[1], i[2], i[3]};
         applyStimulus(1'b0, b);
         checkOutput($sformatf("map_m%0d_i%0d", m, i), {28'd0, leds}, {28'd0, expectedLeds(m, b)});
      end
   endtask

   initial begin
      logic [3:0] chaseExp;
      logic       swSched;
      checkCount = 0;
      errorCount = 0;
      rstN  = 1'b0;
      sw    = 1'b0;
      blink = 4'b0000;

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'($urandom), 4'($urandom));
         checkOutput("rst_mode", {29'd0, mode}, 32'd0);
         checkOutput("rst_leds", {28'd0, leds}, 32'd0);
      end
      sw    = 1'b0;
      blink = 4'b0000;
      rstN  = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0000);

      // Short glitch must be rejected
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, blink);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, blink);
      checkOutput("glitch_mode", {29'd0, mode}, 32'd0);

      // Clean press: mode changes exactly 7 cycles after the raw rise
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, blink);
      checkOutput("latency_early", {29'd0, mode}, 32'd0);
      applyStimulus(1'b1, blink);
      checkOutput("latency_exact", {29'd0, mode}, 32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, blink);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, blink);
      checkOutput("mode_seq1", {29'd0, mode}, 32'd1);

      checkMapping(1);
      for (int m = 2; m <= 5; m++) begin
         pressButton(10);
         checkOutput($sformatf("mode_seq%0d", m), {29'd0, mode}, m);
         checkMapping(m);
      end

      // Enter CHASE and time a second press to land on a chase step
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, blink);
      checkOutput("chase_enter", {29'd0, mode}, 32'd6);
      for (int i = 1; i <= 31; i++) begin
         swSched = (i >= 24) ? 1'b1 : ((i >= 4) ? 1'b0 : 1'b1);
         applyStimulus(swSched, blink);
         chaseExp = (i <= 30) ? (4'b1000 >> (((i - 1) / 3) % 4)) : 4'b1111;
         checkOutput($sformatf("chase_led_%0d", i), {28'd0, leds}, {28'd0, chaseExp});
         checkOutput($sformatf("chase_mode_%0d", i), {29'd0, mode}, (i < 30) ? 32'd6 : 32'd7);
      end
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, blink);
      checkOutput("collide_mode", {29'd0, mode}, 32'd7);
      checkOutput("collide_leds", {28'd0, leds}, 32'hF);

      pressButton(10);
      checkOutput("wrap_mode", {29'd0, mode}, 32'd0);
      checkOutput("wrap_leds", {28'd0, leds}, 32'd0);

      // Long hold advances exactly once
      pressButton(100);
      checkOutput("hold_mode", {29'd0, mode}, 32'd1);
      for (int m = 2; m <= 5; m++) begin
         pressButton(10);
         checkOutput($sformatf("mode_seq_b%0d", m), {29'd0, mode}, m);
      end

      // Re-entering CHASE restarts at LED1
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, blink);
      checkOutput("rechase_mode", {29'd0, mode}, 32'd6);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, blink);
         checkOutput($sformatf("rechase_first_%0d", i), {28'd0, leds}, 32'h8);
      end
      applyStimulus(1'b0, blink);
      checkOutput("rechase_second", {28'd0, leds}, 32'h4);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, blink);

      pressButton(10);
      checkOutput("allon_mode", {29'd0, mode}, 32'd7);
      checkOutput("allon_leds", {28'd0, leds}, 32'hF);

      // Mid-cycle asynchronous reset
      #3;
      rstN = 1'b0;
      #1;
      checkOutput("async_rst_mode", {29'd0, mode}, 32'd0);
      checkOutput("async_rst_leds", {28'd0, leds}, 32'd0);
      applyStimulus(1'b0, blink);
      rstN = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, blink);
      checkOutput("post_rst_mode", {29'd0, mode}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
